// File: rtl/multdiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   - default operand width and iteration counts
//   - sequencer state encoding
//   - radix-4 Booth operation encoding and the bits-to-op mapping
package multdiv_pkg;

   localparam int DEF_WIDTH      = 32;
   localparam int DEF_MULT_STEPS = DEF_WIDTH / 2;
   localparam int DEF_DIV_STEPS  = DEF_WIDTH;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      MULT_RUN = 3'd1,
      DIV_RUN  = 3'd2,
      DIV_FIX  = 3'd3,
      DONE     = 3'd4
   } seqState_t;

   // ADD2/SUB2 select the doubled multiplicand.
   typedef enum logic [2:0] {
      NOP  = 3'd0,
      ADD1 = 3'd1,
      ADD2 = 3'd2,
      SUB1 = 3'd3,
      SUB2 = 3'd4
   } boothOp_t;

   // Radix-4 Booth recoding of product bits [2:0] (bit 0 is the guard bit).
   function automatic boothOp_t boothOp(input logic [2:0] triplet);
      boothOp_t op;
      case (triplet)
         3'b001, 3'b010: op = ADD1;
         3'b011:         op = ADD2;
         3'b100:         op = SUB2;
         3'b101, 3'b110: op = SUB1;
         default:        op = NOP;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/multdiv_sequencer_booth_decoder.sv
// Combinational radix-4 Booth decoder.
// Ports:
//   boothBits  in  3  product register bits [2:0]
//   aluAdd     out 1  add the (possibly doubled) multiplicand
//   aluSub     out 1  subtract the (possibly doubled) multiplicand
//   mcandX2    out 1  use 2x multiplicand
// Outputs are ungated; the sequencer qualifies them with its state.
module booth_decoder
   import multdiv_pkg::*;
(
   input  logic [2:0] boothBits,
   output logic       aluAdd,
   output logic       aluSub,
   output logic       mcandX2
);

   boothOp_t op;

   always_comb begin
      op      = boothOp(boothBits);
      aluAdd  = (op == ADD1) || (op == ADD2);
      aluSub  = (op == SUB1) || (op == SUB2);
      mcandX2 = (op == ADD2) || (op == SUB2);
   end

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequencer for the shared iterative multiply/divide datapath.
// Holds only state, the iteration counter and the mode/div-by-zero flags;
// all operand and product storage lives in the datapath.
// Ports:
//   clock           in   system clock, rising edge
//   ctrl_reset_n    in   asynchronous active-low reset
//   ctrl_MULT       in   start multiply (one-cycle pulse, wins over ctrl_DIV)
//   ctrl_DIV        in   start divide (one-cycle pulse)
//   booth_bits      in   product bits [2:0] for Booth recoding
//   rem_sign        in   sign of the current partial remainder
//   divisor_zero    in   divisor is zero, valid in the start cycle
//   mult_ovf        in   product overflow, valid in the result cycle
//   dp_load         out  load operands (combinational on a start pulse)
//   dp_is_div       out  datapath mode, registered at start
//   alu_add/alu_sub out  add / subtract this step
//   mcand_x2        out  use 2x multiplicand
//   dp_shift        out  shift product or remainder this step
//   dp_fix          out  divide correction step
//   busy            out  operation in progress
//   data_resultRDY  out  one-cycle result-valid pulse
//   data_exception  out  overflow or divide-by-zero, only with data_resultRDY
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a start pulse
// MULT_RUN | one Booth radix-4 step per cycle, MULT_STEPS cycles
// DIV_RUN  | one non-restoring divide step per cycle, DIV_STEPS cycles
// DIV_FIX  | single remainder correction cycle
// DONE     | result valid for one cycle, then IDLE
module multdiv_sequencer
   import multdiv_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int MULT_STEPS = WIDTH / 2,
   parameter int DIV_STEPS  = WIDTH
) (
   input  logic       clock,
   input  logic       ctrl_reset_n,
   input  logic       ctrl_MULT,
   input  logic       ctrl_DIV,
   input  logic [2:0] booth_bits,
   input  logic       rem_sign,
   input  logic       divisor_zero,
   input  logic       mult_ovf,
   output logic       dp_load,
   output logic       dp_is_div,
   output logic       alu_add,
   output logic       alu_sub,
   output logic       mcand_x2,
   output logic       dp_shift,
   output logic       dp_fix,
   output logic       busy,
   output logic       data_resultRDY,
   output logic       data_exception
);

   localparam int CNT_W = $clog2(DIV_STEPS) + 1;
   localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STEPS - 1);
   localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 1);

   seqState_t        state, stateNext;
   logic [CNT_W-1:0] cnt, cntNext;
   logic             isDiv, isDivNext;
   logic             div0, div0Next;

   logic boothAdd, boothSub, boothX2;
   logic inMult, inDivRun, inDivFix;

   booth_decoder uBoothDecoder (
      .boothBits (booth_bits),
      .aluAdd    (boothAdd),
      .aluSub    (boothSub),
      .mcandX2   (boothX2)
   );

   // A start pulse overrides whatever is running, so an aborted operation
   // simply never reaches DONE and produces no result pulse.
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      isDivNext = isDiv;
      div0Next  = div0;
      if (ctrl_MULT) begin
         stateNext = MULT_RUN;
         cntNext   = '0;
         isDivNext = 1'b0;
         div0Next  = 1'b0;
      end else if (ctrl_DIV) begin
         cntNext   = '0;
         isDivNext = 1'b1;
         div0Next  = divisor_zero;
         // Divide by zero issues no steps; the result cycle follows directly.
         stateNext = divisor_zero ? DONE : DIV_RUN;
      end else begin
         case (state)
            MULT_RUN: begin
               if (cnt == MULT_LAST) stateNext = DONE;
               else                  cntNext   = cnt + 1'b1;
            end
            DIV_RUN: begin
               if (cnt == DIV_LAST) stateNext = DIV_FIX;
               else                 cntNext   = cnt + 1'b1;
            end
            DIV_FIX: stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         state <= IDLE;
         cnt   <= '0;
         isDiv <= 1'b0;
         div0  <= 1'b0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
         isDiv <= isDivNext;
         div0  <= div0Next;
      end
   end

   assign inMult   = (state == MULT_RUN);
   assign inDivRun = (state == DIV_RUN);
   assign inDivFix = (state == DIV_FIX);

   assign dp_load   = ctrl_MULT | ctrl_DIV;
   assign dp_is_div = isDiv;

   // Non-restoring divide: subtract while the remainder is non-negative,
   // add back while it is negative; the fix cycle adds only if negative.
   assign alu_add  = (inMult & boothAdd) | ((inDivRun | inDivFix) & rem_sign);
   assign alu_sub  = (inMult & boothSub) | (inDivRun & ~rem_sign);
   assign mcand_x2 = inMult & boothX2;
   assign dp_shift = inMult | inDivRun;
   assign dp_fix   = inDivFix;

   assign busy           = inMult | inDivRun | inDivFix;
   assign data_resultRDY = (state == DONE);
   assign data_exception = data_resultRDY & (isDiv ? div0 : mult_ovf);

endmodule

// File: tb/tb_multdiv_sequencer.sv
module tb_multdiv_sequencer;
   import multdiv_pkg::*;

   localparam int MS = DEF_MULT_STEPS;
   localparam int DS = DEF_DIV_STEPS;

   logic       clock = 1'b0;
   logic       ctrl_reset_n = 1'b0;
   logic       ctrl_MULT = 1'b0;
   logic       ctrl_DIV = 1'b0;
   logic [2:0] booth_bits = 3'b000;
   logic       rem_sign = 1'b0;
   logic       divisor_zero = 1'b0;
   logic       mult_ovf = 1'b0;
   logic       dp_load, dp_is_div, alu_add, alu_sub, mcand_x2, dp_shift, dp_fix;
   logic       busy, data_resultRDY, data_exception;

   multdiv_sequencer dut (
      .clock          (clock),
      .ctrl_reset_n   (ctrl_reset_n),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .booth_bits     (booth_bits),
      .rem_sign       (rem_sign),
      .divisor_zero   (divisor_zero),
      .mult_ovf       (mult_ovf),
      .dp_load        (dp_load),
      .dp_is_div      (dp_is_div),
      .alu_add        (alu_add),
      .alu_sub        (alu_sub),
      .mcand_x2       (mcand_x2),
      .dp_shift       (dp_shift),
      .dp_fix         (dp_fix),
      .busy           (busy),
      .data_resultRDY (data_resultRDY),
      .data_exception (data_exception)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit isDiv;
      bit exc;
      int due;
   } expect_t;

   expect_t sb[$];
   int nVec = 0;
   int nMis = 0;
   int cyc  = 0;

   task automatic checkEq(input string tag, input int got, input int exp);
      nVec++;
      if (got != exp) begin
         nMis++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic expectCtl(input bit a, input bit s, input bit x2, input bit sh,
                            input bit fx, input bit bsy);
      checkEq("alu_add", alu_add, a);
      checkEq("alu_sub", alu_sub, s);
      checkEq("mcand_x2", mcand_x2, x2);
      checkEq("dp_shift", dp_shift, sh);
      checkEq("dp_fix", dp_fix, fx);
      checkEq("busy", busy, bsy);
   endtask

   // Advance one clock, drive step inputs, then compare any result pulse
   // against the oldest outstanding expectation.
   task automatic tick(input logic [2:0] bb, input logic rs);
      expect_t e;
      @(posedge clock);
      #1;
      ctrl_MULT  = 1'b0;
      ctrl_DIV   = 1'b0;
      booth_bits = bb;
      rem_sign   = rs;
      #1;
      cyc++;
      if (data_resultRDY) begin
         if (sb.size() == 0) begin
            checkEq("rdyUnexpected", data_resultRDY, 0);
         end else begin
            e = sb.pop_front();
            checkEq("rdyCycle", cyc, e.due);
            checkEq("exception", data_exception, e.exc);
            checkEq("isDiv", dp_is_div, e.isDiv);
         end
      end else begin
         checkEq("excGate", data_exception, 0);
         if (sb.size() > 0 && cyc > sb[0].due) begin
            checkEq("rdyMissed", cyc, sb[0].due);
            sb.delete(0);
         end
      end
   endtask

   // Assert a start pulse in the current cycle; the next tick is edge 0.
   task automatic startOp(input logic m, input logic d, input logic dz,
                          input int lat, input bit exc);
      expect_t e;
      if (busy && sb.size() > 0) sb.delete(sb.size() - 1);
      ctrl_MULT    = m;
      ctrl_DIV     = d;
      divisor_zero = dz;
      #1;
      checkEq("dp_load", dp_load, 1);
      e.isDiv = !m;
      e.exc   = exc;
      e.due   = cyc + lat;
      sb.push_back(e);
   endtask

   initial begin
      logic [2:0] bb;
      logic       rs;
      bit         ea, es, ex;

      // reset state
      #12;
      expectCtl(0, 0, 0, 0, 0, 0);
      checkEq("rstRdy", data_resultRDY, 0);
      checkEq("rstIsDiv", dp_is_div, 0);
      checkEq("rstExc", data_exception, 0);
      checkEq("rstLoad", dp_load, 0);
      ctrl_reset_n = 1'b1;
      tick(3'b000, 1'b0);

      // multiply, booth 011 every step, overflow reported
      mult_ovf = 1'b1;
      startOp(1, 0, 0, MS + 1, 1);
      for (int k = 1; k <= MS + 3; k++) begin
         tick(3'b011, 1'b0);
         if (k <= MS) expectCtl(1, 0, 1, 1, 0, 1);
         else         expectCtl(0, 0, 0, 0, 0, 0);
      end

      // multiply, sweep all Booth codes
      mult_ovf = 1'b0;
      startOp(1, 0, 0, MS + 1, 0);
      for (int k = 1; k <= MS + 2; k++) begin
         bb = k[2:0];
         rs = k[3];
         tick(bb, rs);
         case (bb)
            3'b001, 3'b010: {ea, es, ex} = 3'b100;
            3'b011:         {ea, es, ex} = 3'b101;
            3'b100:         {ea, es, ex} = 3'b011;
            3'b101, 3'b110: {ea, es, ex} = 3'b010;
            default:        {ea, es, ex} = 3'b000;
         endcase
         if (k <= MS) expectCtl(ea, es, ex, 1, 0, 1);
         else         expectCtl(0, 0, 0, 0, 0, 0);
      end

      // divide, remainder sign toggling; mult_ovf must not leak
      mult_ovf = 1'b1;
      startOp(0, 1, 0, DS + 2, 0);
      for (int k = 1; k <= DS + 3; k++) begin
         rs = k[0];
         tick(3'b011, rs);
         if (k <= DS)          expectCtl(rs, !rs, 0, 1, 0, 1);
         else if (k == DS + 1) expectCtl(rs, 0, 0, 0, 1, 1);
         else                  expectCtl(0, 0, 0, 0, 0, 0);
      end
      checkEq("divHoldIsDiv", dp_is_div, 1);

      // divide by zero
      mult_ovf = 1'b0;
      startOp(0, 1, 1, 1, 1);
      for (int k = 1; k <= 3; k++) begin
         tick(3'b011, 1'b1);
         expectCtl(0, 0, 0, 0, 0, 0);
      end

      // reset in the middle of a multiply
      startOp(1, 0, 0, MS + 1, 0);
      for (int k = 1; k <= 5; k++) begin
         tick(3'b000, 1'b0);
         checkEq("midBusy", busy, 1);
      end
      #1;
      ctrl_reset_n = 1'b0;
      #1;
      checkEq("rstMidBusy", busy, 0);
      checkEq("rstMidRdy", data_resultRDY, 0);
      checkEq("rstMidShift", dp_shift, 0);
      sb.delete();
      #1;
      ctrl_reset_n = 1'b1;
      tick(3'b000, 1'b0);
      checkEq("postRstBusy", busy, 0);
      startOp(1, 0, 0, MS + 1, 0);
      for (int k = 1; k <= MS + 2; k++) begin
         tick(3'b000, 1'b0);
         if (k <= MS) expectCtl(0, 0, 0, 1, 0, 1);
         else         expectCtl(0, 0, 0, 0, 0, 0);
      end

      // multiply aborted by a divide start at cycle 7
      startOp(1, 0, 0, MS + 1, 0);
      for (int k = 1; k <= 7; k++) tick(3'b001, 1'b0);
      startOp(0, 1, 0, DS + 2, 0);
      for (int k = 1; k <= DS + 4; k++) begin
         tick(3'b001, 1'b0);
         if (k <= DS) expectCtl(0, 1, 0, 1, 0, 1);
      end

      // simultaneous starts: multiply wins, divisor_zero ignored
      startOp(1, 1, 1, MS + 1, 0);
      for (int k = 1; k <= MS + 2; k++) begin
         tick(3'b110, 1'b1);
         if (k <= MS) expectCtl(0, 1, 0, 1, 0, 1);
      end
      checkEq("bothIsDiv", dp_is_div, 0);

      checkEq("sbEmpty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Central controller for the shared iterative multiply/divide datapath (radix-4 Booth product register plus non-restoring divide).
- Accepts one-cycle ctrl_MULT / ctrl_DIV start pulses and issues load and per-step datapath controls.
- Counts iterations and produces the data_resultRDY pulse and the qualified data_exception.
- The datapath holds all operand/product storage; this block holds only state, counter and flags.

Parameters:
WIDTH, 32, operand width; must be even.
MULT_STEPS, WIDTH/2, Booth radix-4 iterations.
DIV_STEPS, WIDTH, non-restoring divide iterations (one correction step follows).

Ports:
clock  in  1  single system clock, rising edge.
ctrl_reset_n  in  1  asynchronous, active-low reset.
ctrl_MULT  in  1  start multiply, one-cycle pulse.
ctrl_DIV  in  1  start divide, one-cycle pulse.
booth_bits  in  3  product register bits [2:0] from datapath.
rem_sign  in  1  sign of current partial remainder.
divisor_zero  in  1  divisor operand == 0; valid in the start cycle.
mult_ovf  in  1  datapath product overflow check; valid in the RDY cycle.
dp_load  out  1  load initial operands; combinational = ctrl_MULT | ctrl_DIV.
dp_is_div  out  1  datapath mode select; registered at start.
alu_add  out  1  add multiplicand/divisor this step.
alu_sub  out  1  subtract this step.
mcand_x2  out  1  use 2x multiplicand (Booth 011/100).
dp_shift  out  1  shift product (>>>2) or remainder (<<1) this step.
dp_fix  out  1  divide correction step (add divisor if remainder negative).
busy  out  1  operation in progress.
data_resultRDY  out  1  one-cycle result-valid pulse.
data_exception  out  1  valid only while data_resultRDY = 1.

Behaviour:
- Reset (asynchronous, active-low): state = IDLE, counter = 0, all flags cleared. Every registered output is 0; alu_*/dp_* are 0.
- States: IDLE, MULT_RUN, DIV_RUN, DIV_FIX, DONE.
- Start (from any state): on a clock edge with ctrl_MULT=1, enter MULT_RUN with cnt=0.
  - ctrl_DIV=1 enters DIV_RUN.
  - Both high: MULT wins; DIV is ignored.
  - A start while busy aborts the current operation and restarts. No RDY pulse is issued for the aborted operation.
- MULT_RUN: each cycle decodes booth_bits.
  - 000/111: no ALU op.
  - 001/010: alu_add.
  - 011: alu_add + mcand_x2.
  - 100: alu_sub + mcand_x2.
  - 101/110: alu_sub.
  - dp_shift=1 every step; cnt increments.
  - After step MULT_STEPS-1, go to DONE.
- DIV_RUN: dp_shift=1 each step. alu_sub if rem_sign=0, alu_add if rem_sign=1. After step DIV_STEPS-1, go to DIV_FIX.
- DIV_FIX: dp_fix=1, alu_add=rem_sign; one cycle, then DONE.
- Divide by zero: divisor_zero sampled at the start edge. Skip straight to DONE and latch div0=1; no steps are issued.
- DONE: data_resultRDY=1 for exactly one cycle, busy=0, then IDLE.
- data_exception = data_resultRDY & (dp_is_div ? div0 : mult_ovf). It is 0 in all other cycles.
- Latency, with start edge = edge 0:
  - MULT: steps on edges 1..16, RDY high the cycle after edge 16.
  - DIV: steps on edges 1..32, fix on edge 33, RDY the cycle after edge 33.
  - DIV by zero: RDY the cycle after edge 0.
- busy is high from the cycle after the start edge until RDY. It is low during the RDY cycle.
- Step controls (alu_*, mcand_x2, dp_shift, dp_fix) are combinational from state and inputs. All are 0 in IDLE and DONE.
- Counter width is $clog2(DIV_STEPS)+1. The counter never wraps; terminal compare is exact.
- dp_is_div holds its value through DONE and changes only on the next start.

Decomposition:
- multdiv_pkg holds:
  - the state enum (IDLE, MULT_RUN, DIV_RUN, DIV_FIX, DONE);
  - the Booth op enum (NOP, ADD1, ADD2, SUB1, SUB2);
  - the MULT_STEPS and DIV_STEPS default constants.
- Sub-module booth_decoder: combinational, booth_bits[2:0] -> alu_add, alu_sub, mcand_x2. Instantiated once and gated by state == MULT_RUN.

Test Plan:
- Reset mid-MULT (deassert ctrl_reset_n at cycle 5) -> next cycle busy=0, RDY=0, state IDLE; a later ctrl_MULT completes normally in 17 cycles.
- ctrl_MULT pulse, booth_bits forced to 011 every cycle -> alu_add=1, mcand_x2=1, dp_shift=1 for exactly 16 cycles; RDY exactly one cycle at cycle 17; mult_ovf=1 then gives data_exception=1.
- ctrl_DIV with divisor_zero=0, rem_sign toggling -> 32 steps with alu_sub = !rem_sign, then dp_fix one cycle, RDY at cycle 34, data_exception=0.
- ctrl_DIV with divisor_zero=1 -> no step controls, RDY and data_exception both 1 at cycle 1.
- ctrl_MULT at cycle 0, ctrl_DIV at cycle 7 -> multiply aborted with no RDY pulse; divide RDY at cycle 41; dp_is_div=1.
- ctrl_MULT and ctrl_DIV in the same cycle -> multiply sequence only, dp_is_div=0, RDY at cycle 17.
